// File: rtl/grf_wb_if.sv
// grf_wb_if
// Bundles the W-stage write request, the D-stage read ports and the
// commit record of the general register file.
//   master : pipeline side, drives RegWrite/A1/A2/A3/WData/PC_W,
//            receives RD1/RD2 and the commit record
//   slave  : register file side (grf_wb)
// Parameter CNT_W sets the commit counter width and must match grf_wb.
interface grf_wb_if #(
    parameter int CNT_W = 16
);
    logic             RegWrite;
    logic [4:0]       A1;
    logic [4:0]       A2;
    logic [4:0]       A3;
    logic [31:0]      WData;
    logic [31:0]      PC_W;
    logic [31:0]      RD1;
    logic [31:0]      RD2;
    logic [CNT_W-1:0] commit_cnt;
    logic [31:0]      last_pc;
    logic [4:0]       last_reg;
    logic [31:0]      last_data;

    modport master (
        output RegWrite, A1, A2, A3, WData, PC_W,
        input  RD1, RD2, commit_cnt, last_pc, last_reg, last_data
    );

    modport slave (
        input  RegWrite, A1, A2, A3, WData, PC_W,
        output RD1, RD2, commit_cnt, last_pc, last_reg, last_data
    );
endinterface

// File: rtl/grf_wb.sv
// grf_wb
// Writeback-side 32x32 general register file for the five-stage MIPS
// pipeline. Commits the W-stage word into the array and serves the two
// combinational D-stage read ports. Also keeps a wrapping count of
// effective writes and a record of the most recent one (PC, register, data).
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low clear of array, counter and record
//   bus   : grf_wb_if.slave (RegWrite, A1, A2, A3, WData, PC_W in;
//           RD1, RD2, commit_cnt, last_pc, last_reg, last_data out)
// Build option:
//   GRF_BYPASS_EN : when defined, a same-cycle write to the register being
//                   read is forwarded from WData to RD1/RD2 (outside reset).
//                   When undefined, reads return array contents only.
module grf_wb #(
    parameter int CNT_W = 16
) (
    input logic     clk,
    input logic     reset,
    grf_wb_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] data;
    } commit_t;

    logic [31:0]      regs [32];
    logic [CNT_W-1:0] cnt;
    commit_t          last;
    logic             wr_en;
    logic [31:0]      rd1;
    logic [31:0]      rd2;

    // $0 is hard-wired: writes to it are not effective and are not counted.
    assign wr_en = bus.RegWrite && (bus.A3 != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            cnt  <= '0;
            last <= '0;
        end else if (wr_en) begin
            regs[bus.A3] <= bus.WData;
            cnt          <= cnt + CNT_W'(1);  // wraps silently
            last         <= '{pc: bus.PC_W, dst: bus.A3, data: bus.WData};
        end
    end

    always_comb begin
        rd1 = (bus.A1 == 5'd0) ? 32'd0 : regs[bus.A1];
        rd2 = (bus.A2 == 5'd0) ? 32'd0 : regs[bus.A2];
`ifdef GRF_BYPASS_EN
        // W->D same-cycle forward; suppressed while reset is asserted since
        // the write will be dropped at the edge.
        if (reset && wr_en && (bus.A3 == bus.A1)) rd1 = bus.WData;
        if (reset && wr_en && (bus.A3 == bus.A2)) rd2 = bus.WData;
`endif
    end

    assign bus.RD1        = rd1;
    assign bus.RD2        = rd2;
    assign bus.commit_cnt = cnt;
    assign bus.last_pc    = last.pc;
    assign bus.last_reg   = last.dst;
    assign bus.last_data  = last.data;

endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb
// Self-checking bench for grf_wb. A reference register file and commit
// record are updated on every edge; expected outputs are pushed to a
// scoreboard queue as stimulus is driven and popped by each test task.
// Uses CNT_W=4 so the counter wrap is reachable in a few writes.
module tb_grf_wb;
    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0]      rd1;
        logic [31:0]      rd2;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      pc;
        logic [4:0]       rg;
        logic [31:0]      data;
    } exp_t;

    logic clk;
    logic reset;
    grf_wb_if #(.CNT_W(CNT_W)) bus ();

    grf_wb #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // reference model
    logic [31:0]      m_grf [32];
    logic [CNT_W-1:0] m_cnt;
    logic [31:0]      m_pc;
    logic [4:0]       m_reg;
    logic [31:0]      m_data;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, take the edge, update the model and push
    // the expected post-edge outputs; returns 1 time unit after the edge.
    task automatic drive_edge(input logic rst, input logic we, input logic [4:0] a3,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic [4:0] a1, input logic [4:0] a2);
        exp_t x;
        reset        = rst;
        bus.RegWrite = we;
        bus.A3       = a3;
        bus.WData    = wd;
        bus.PC_W     = pc;
        bus.A1       = a1;
        bus.A2       = a2;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
            m_cnt = '0; m_pc = '0; m_reg = '0; m_data = '0;
        end else if (we && a3 != 5'd0) begin
            m_grf[a3] = wd;
            m_cnt     = m_cnt + 1'b1;
            m_pc      = pc;
            m_reg     = a3;
            m_data    = wd;
        end
        x.rd1  = (a1 == 5'd0) ? 32'd0 : m_grf[a1];
        x.rd2  = (a2 == 5'd0) ? 32'd0 : m_grf[a2];
        x.cnt  = m_cnt;
        x.pc   = m_pc;
        x.rg   = m_reg;
        x.data = m_data;
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        drive_edge(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd9);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL init_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL init_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        drive_edge(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h3000, 5'd5, 5'd9);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL pre_reset_rd1: got %h exp %h", bus.RD1, e.rd1); end
        drive_edge(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'h3004, 5'd5, 5'd9);
        e = sb.pop_front();
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL pre_reset_rd2: got %h exp %h", bus.RD2, e.rd2); end
        drive_edge(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd9);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL reset_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL reset_rd2: got %h exp %h", bus.RD2, e.rd2); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL reset_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        checks++; if (bus.last_pc !== e.pc) begin errors++; $display("FAIL reset_last_pc: got %h exp %h", bus.last_pc, e.pc); end
    endtask

    task automatic test_normal_write();
        drive_edge(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h0000_3008, 5'd8, 5'd0);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL wr_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL wr_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        checks++; if (bus.last_reg !== e.rg) begin errors++; $display("FAIL wr_last_reg: got %0d exp %0d", bus.last_reg, e.rg); end
        checks++; if (bus.last_pc !== e.pc) begin errors++; $display("FAIL wr_last_pc: got %h exp %h", bus.last_pc, e.pc); end
        checks++; if (bus.last_data !== e.data) begin errors++; $display("FAIL wr_last_data: got %h exp %h", bus.last_data, e.data); end
    endtask

    task automatic test_zero_write();
        drive_edge(1'b1, 1'b1, 5'd0, 32'h5555_5555, 32'h0000_300C, 5'd0, 5'd8);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL zero_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL zero_rd2: got %h exp %h", bus.RD2, e.rd2); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL zero_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        checks++; if (bus.last_pc !== e.pc) begin errors++; $display("FAIL zero_last_pc: got %h exp %h", bus.last_pc, e.pc); end
        checks++; if (bus.last_reg !== e.rg) begin errors++; $display("FAIL zero_last_reg: got %0d exp %0d", bus.last_reg, e.rg); end
        checks++; if (bus.last_data !== e.data) begin errors++; $display("FAIL zero_last_data: got %h exp %h", bus.last_data, e.data); end
    endtask

    task automatic test_hazard();
        exp_t x;
        drive_edge(1'b1, 1'b1, 5'd3, 32'h1, 32'h0000_3010, 5'd3, 5'd3);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL hz_setup_rd1: got %h exp %h", bus.RD1, e.rd1); end
        // same-cycle write of $3 while both ports read it, observed pre-edge
        bus.RegWrite = 1'b1; bus.A3 = 5'd3; bus.WData = 32'h2; bus.PC_W = 32'h0000_3014;
        bus.A1 = 5'd3; bus.A2 = 5'd3;
`ifdef GRF_BYPASS_EN
        x.rd1 = 32'h2; x.rd2 = 32'h2;
`else
        x.rd1 = m_grf[3]; x.rd2 = m_grf[3];
`endif
        x.cnt = m_cnt; x.pc = m_pc; x.rg = m_reg; x.data = m_data;
        sb.push_back(x);
        #1;
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL hz_pre_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL hz_pre_rd2: got %h exp %h", bus.RD2, e.rd2); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL hz_pre_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        drive_edge(1'b1, 1'b1, 5'd3, 32'h2, 32'h0000_3014, 5'd3, 5'd3);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL hz_post_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL hz_post_rd2: got %h exp %h", bus.RD2, e.rd2); end
    endtask

    task automatic test_reset_beats_write();
        drive_edge(1'b1, 1'b1, 5'd4, 32'h0000_0099, 32'h0000_3018, 5'd4, 5'd3);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL rbw_setup_rd1: got %h exp %h", bus.RD1, e.rd1); end
        drive_edge(1'b0, 1'b1, 5'd4, 32'h0000_0077, 32'h0000_301C, 5'd4, 5'd3);
        e = sb.pop_front();
        checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL rbw_rd1: got %h exp %h", bus.RD1, e.rd1); end
        checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL rbw_rd2: got %h exp %h", bus.RD2, e.rd2); end
        checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL rbw_cnt: got %0d exp %0d", bus.commit_cnt, e.cnt); end
        checks++; if (bus.last_data !== e.data) begin errors++; $display("FAIL rbw_last_data: got %h exp %h", bus.last_data, e.data); end
    endtask

    // 17 back-to-back effective writes after a mid-run reset: the first
    // yields count 1, the 17th wraps the 4-bit counter back to 1.
    task automatic test_back_to_back();
        logic [4:0]  a3;
        logic [31:0] wd;
        drive_edge(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        e = sb.pop_front();
        for (int i = 0; i < 17; i++) begin
            a3 = 5'((i % 31) + 1);
            wd = $urandom;
            drive_edge(1'b1, 1'b1, a3, wd, 32'h0000_4000 + 32'(i * 4), a3, 5'(i));
            e = sb.pop_front();
            checks++; if (bus.RD1 !== e.rd1) begin errors++; $display("FAIL b2b_rd1[%0d]: got %h exp %h", i, bus.RD1, e.rd1); end
            checks++; if (bus.RD2 !== e.rd2) begin errors++; $display("FAIL b2b_rd2[%0d]: got %h exp %h", i, bus.RD2, e.rd2); end
            checks++; if (bus.commit_cnt !== e.cnt) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d exp %0d", i, bus.commit_cnt, e.cnt); end
        end
        checks++; if (bus.commit_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", bus.commit_cnt); end
        checks++; if (bus.last_reg !== e.rg) begin errors++; $display("FAIL wrap_last_reg: got %0d exp %0d", bus.last_reg, e.rg); end
        checks++; if (bus.last_data !== e.data) begin errors++; $display("FAIL wrap_last_data: got %h exp %h", bus.last_data, e.data); end
        checks++; if (bus.last_pc !== e.pc) begin errors++; $display("FAIL wrap_last_pc: got %h exp %h", bus.last_pc, e.pc); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
        m_cnt = '0; m_pc = '0; m_reg = '0; m_data = '0;
        reset = 1'b0;
        bus.RegWrite = 1'b0; bus.A1 = '0; bus.A2 = '0; bus.A3 = '0;
        bus.WData = '0; bus.PC_W = '0;
        test_reset();
        test_normal_write();
        test_zero_write();
        test_hazard();
        test_reset_beats_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
